retrieve_stream: RTL and testbench

Clocked, parametrised read-side engine for the ring-buffer receive path. It owns a read pointer into a DEPTH-entry, WIDTH-bit shared storage array and compares it against the write pointer supplied by the storage side. It delivers entries in order through a registered valid/ready output, and reports occupancy, empty, overrun and underflow. It sits between the ring-buffer storage and the downstream receive consumer, and replaces the combinational single-bit decode/gate stage.

---
 rtl/ringbuf_pkg.sv | 23 ++
 rtl/retrieve_stream_entry_mux.sv | 15 +
 rtl/retrieve_stream.sv | 101 ++++++++++
 tb/tb_retrieve_stream.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ringbuf_pkg.sv
// Shared definitions for the ring-buffer receive path: default sizes, the read
// FSM encoding and the modular pointer-difference helper.
package ringbuf_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_ADDR_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Pointers carry one wrap bit above the index, so the difference is taken
  // modulo 2**ptr_w; callers truncate the result to their pointer width.
  function automatic logic [31:0] ptr_diff(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input int          ptr_w);
    logic [31:0] mask;
    mask = (32'd1 << ptr_w) - 32'd1;
    return (a - b) & mask;
  endfunction

endpackage

// File: rtl/retrieve_stream_entry_mux.sv
// Combinational DEPTH:1 selector picking one WIDTH-bit entry out of the
// flattened storage array.
module entry_mux #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4,
  localparam int DEPTH = 2 ** ADDR_W
) (
  input  logic [WIDTH*DEPTH-1:0] buffer_i,
  input  logic [ADDR_W-1:0]      idx_i,
  output logic [WIDTH-1:0]       entry_o
);

  assign entry_o = buffer_i[idx_i*WIDTH +: WIDTH];

endmodule

// File: rtl/retrieve_stream.sv
// Read-side engine of the ring buffer: pops entries in order into a registered
// valid/ready output and tracks occupancy, underflow and overrun.
module retrieve_stream
  import ringbuf_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = DEF_ADDR_W,
  localparam int DEPTH = 2 ** ADDR_W,
  localparam int PTR_W = ADDR_W + 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   outstrobe,
  input  logic                   flush,
  input  logic [WIDTH*DEPTH-1:0] buffer,
  input  logic [PTR_W-1:0]       ramadrs,
  output logic [WIDTH-1:0]       rxd,
  output logic                   rxd_valid,
  input  logic                   rxd_ready,
  output logic [PTR_W-1:0]       rd_ptr,
  output logic [PTR_W-1:0]       level,
  output logic                   empty,
  output logic                   underflow,
  output logic                   overrun
);

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0]  rxd_q, rxd_d;
  logic              underflow_q, underflow_d;
  logic              overrun_q, overrun_d;

  logic [WIDTH-1:0]  head_entry;
  logic              slot_free;
  logic              pop;

  entry_mux #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_entry_mux (
    .buffer_i (buffer),
    .idx_i    (rd_ptr_q[ADDR_W-1:0]),
    .entry_o  (head_entry)
  );

  // Occupancy uses the pre-edge pointers, so a simultaneous write and pop
  // both see the same snapshot.
  assign level = PTR_W'(ptr_diff(32'(ramadrs), 32'(rd_ptr_q), PTR_W));
  assign empty = (rd_ptr_q == ramadrs);

  assign slot_free = (state_q == IDLE) || rxd_ready;
  assign pop       = outstrobe && !empty && slot_free;

  // NOTE: every variable gets its default before any branch; a path that left
  // one unassigned would infer a latch instead of combinational logic.
  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    rxd_d       = rxd_q;
    underflow_d = underflow_q || (outstrobe && empty && slot_free);
    overrun_d   = overrun_q || (level > PTR_W'(DEPTH));

    if (flush) begin
      rd_ptr_d    = ramadrs;
      state_d     = IDLE;
      underflow_d = 1'b0;
      overrun_d   = 1'b0;
    end else if (pop) begin
      rxd_d    = head_entry;
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      state_d  = HOLD;
    end else if (state_q == HOLD && rxd_ready) begin
      state_d = IDLE;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      rd_ptr_q    <= '0;
      rxd_q       <= '0;
      underflow_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      rxd_q       <= rxd_d;
      underflow_q <= underflow_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rxd       = rxd_q;
  assign rxd_valid = (state_q == HOLD);
  assign rd_ptr    = rd_ptr_q;
  assign underflow = underflow_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_retrieve_stream.sv
// Directed bench for retrieve_stream: a scoreboard queue holds the entries the
// consumer should receive, and register/flag values are checked after edges.
module tb_retrieve_stream;

  localparam int WIDTH  = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int PTR_W  = ADDR_W + 1;

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   outstrobe;
  logic                   flush;
  logic [WIDTH*DEPTH-1:0] buffer;
  logic [PTR_W-1:0]       ramadrs;
  logic [WIDTH-1:0]       rxd;
  logic                   rxd_valid;
  logic                   rxd_ready;
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W-1:0]       level;
  logic                   empty;
  logic                   underflow;
  logic                   overrun;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q[$];

  retrieve_stream #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .outstrobe (outstrobe),
    .flush     (flush),
    .buffer    (buffer),
    .ramadrs   (ramadrs),
    .rxd       (rxd),
    .rxd_valid (rxd_valid),
    .rxd_ready (rxd_ready),
    .rd_ptr    (rd_ptr),
    .level     (level),
    .empty     (empty),
    .underflow (underflow),
    .overrun   (overrun)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_entry(input int k, input logic [WIDTH-1:0] v);
    buffer[k*WIDTH +: WIDTH] = v;
  endtask

  // One clock: a handshake seen before the edge delivers rxd to the consumer,
  // which is compared against the scoreboard head. Outputs settle by #1.
  task automatic tick();
    logic             accept;
    logic [WIDTH-1:0] data;
    accept = rxd_valid && rxd_ready;
    data   = rxd;
    @(posedge clock);
    #1;
    if (accept) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_extra: observed %0h expected no delivery", data);
      end else begin
        check("sb_data", 32'(data), 32'(exp_q.pop_front()));
      end
    end
  endtask

  initial begin
    reset = 1'b1; outstrobe = 1'b0; flush = 1'b0; rxd_ready = 1'b0;
    buffer = '0; ramadrs = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_rd_ptr",    32'(rd_ptr),    32'd0);
    check("rst_rxd",       32'(rxd),       32'h0);
    check("rst_valid",     32'(rxd_valid), 32'd0);
    check("rst_underflow", 32'(underflow), 32'd0);
    check("rst_overrun",   32'(overrun),   32'd0);
    check("rst_empty",     32'(empty),     32'd1);
    check("rst_level",     32'(level),     32'd0);

    // Basic stream of three entries, then underflow on the next strobe.
    set_entry(0, 8'hA1); set_entry(1, 8'hB2); set_entry(2, 8'hC3);
    exp_q.push_back(8'hA1); exp_q.push_back(8'hB2); exp_q.push_back(8'hC3);
    ramadrs = 5'd3; rxd_ready = 1'b1; outstrobe = 1'b1;
    #1;
    check("basic_level", 32'(level), 32'd3);
    tick();
    check("basic_rxd0",   32'(rxd),       32'hA1);
    check("basic_valid0", 32'(rxd_valid), 32'd1);
    tick();
    check("basic_rxd1", 32'(rxd), 32'hB2);
    tick();
    check("basic_rxd2",   32'(rxd),       32'hC3);
    check("basic_ptr",    32'(rd_ptr),    32'd3);
    check("basic_empty",  32'(empty),     32'd1);
    check("basic_no_uf",  32'(underflow), 32'd0);
    tick();
    check("basic_uf",     32'(underflow), 32'd1);
    check("basic_idle",   32'(rxd_valid), 32'd0);
    check("basic_ptr_hold", 32'(rd_ptr),  32'd3);
    check("basic_sb_drained", 32'(exp_q.size()), 32'd0);

    // Backpressure: four entries, ready held low for five cycles.
    outstrobe = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_uf_clr", 32'(underflow), 32'd0);
    check("flush_ptr",    32'(rd_ptr),    32'd3);
    set_entry(3, 8'h10); set_entry(4, 8'h20); set_entry(5, 8'h30); set_entry(6, 8'h40);
    exp_q.push_back(8'h10); exp_q.push_back(8'h20);
    exp_q.push_back(8'h30); exp_q.push_back(8'h40);
    ramadrs = 5'd7; rxd_ready = 1'b0; outstrobe = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_rxd",   32'(rxd),       32'h10);
      check("bp_ptr",   32'(rd_ptr),    32'd4);
      check("bp_valid", 32'(rxd_valid), 32'd1);
      tick();
    end
    rxd_ready = 1'b1;
    tick();
    check("bp_rxd1", 32'(rxd), 32'h20);
    check("bp_gap1", 32'(rxd_valid), 32'd1);
    tick();
    check("bp_rxd2", 32'(rxd), 32'h30);
    check("bp_gap2", 32'(rxd_valid), 32'd1);
    tick();
    check("bp_rxd3", 32'(rxd), 32'h40);
    check("bp_ptr_end", 32'(rd_ptr), 32'd7);
    outstrobe = 1'b0;
    tick();
    check("bp_idle", 32'(rxd_valid), 32'd0);
    check("bp_sb_drained", 32'(exp_q.size()), 32'd0);

    // Wrap: read pointer 5'b01110, write pointer 5'b10010.
    ramadrs = 5'b01110; flush = 1'b1;
    tick();
    flush = 1'b0;
    check("wrap_start_ptr", 32'(rd_ptr), 32'b01110);
    set_entry(14, 8'hE0); set_entry(15, 8'hF1); set_entry(0, 8'h02); set_entry(1, 8'h13);
    exp_q.push_back(8'hE0); exp_q.push_back(8'hF1);
    exp_q.push_back(8'h02); exp_q.push_back(8'h13);
    ramadrs = 5'b10010; outstrobe = 1'b1; rxd_ready = 1'b1;
    #1;
    check("wrap_level4", 32'(level), 32'd4);
    tick(); check("wrap_rxd14", 32'(rxd), 32'hE0); check("wrap_level3", 32'(level), 32'd3);
    tick(); check("wrap_rxd15", 32'(rxd), 32'hF1); check("wrap_level2", 32'(level), 32'd2);
    tick(); check("wrap_rxd0",  32'(rxd), 32'h02); check("wrap_level1", 32'(level), 32'd1);
    outstrobe = 1'b0;
    #1;
    outstrobe = 1'b1;
    tick(); check("wrap_rxd1",  32'(rxd), 32'h13); check("wrap_level0", 32'(level), 32'd0);
    check("wrap_ptr",   32'(rd_ptr), 32'b10010);
    check("wrap_empty", 32'(empty),  32'd1);
    check("wrap_no_uf", 32'(underflow), 32'd0);
    outstrobe = 1'b0;
    tick();
    check("wrap_sb_drained", 32'(exp_q.size()), 32'd0);

    // Overrun: level 16 is legal, level 17 means the writer lapped the reader.
    ramadrs = 5'd2;  // 18 + 16 mod 32
    #1;
    check("ovr_level16", 32'(level), 32'd16);
    tick();
    check("ovr_at_depth", 32'(overrun), 32'd0);
    ramadrs = 5'd3;  // 18 + 17 mod 32
    #1;
    check("ovr_level17", 32'(level), 32'd17);
    check("ovr_not_yet", 32'(overrun), 32'd0);
    tick();
    check("ovr_set", 32'(overrun), 32'd1);
    ramadrs = 5'd23;
    tick();
    check("ovr_sticky", 32'(overrun), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("ovr_flush_clr",  32'(overrun), 32'd0);
    check("ovr_flush_ptr",  32'(rd_ptr),  32'd23);
    check("ovr_flush_lvl",  32'(level),   32'd0);
    check("ovr_flush_empty", 32'(empty),  32'd1);

    // Reset in HOLD with ready low: the undelivered entry is dropped.
    set_entry(7, 8'h5A);
    ramadrs = 5'd24; rxd_ready = 1'b0; outstrobe = 1'b1;
    tick();
    check("hold_rxd",   32'(rxd),       32'h5A);
    check("hold_valid", 32'(rxd_valid), 32'd1);
    outstrobe = 1'b0; ramadrs = 5'd9;  // 24 + 17 mod 32
    tick();
    check("hold_ovr", 32'(overrun), 32'd1);
    reset = 1'b1; ramadrs = 5'd0;
    tick();
    reset = 1'b0;
    check("mid_rst_valid", 32'(rxd_valid), 32'd0);
    check("mid_rst_rxd",   32'(rxd),       32'h0);
    check("mid_rst_ptr",   32'(rd_ptr),    32'd0);
    check("mid_rst_uf",    32'(underflow), 32'd0);
    check("mid_rst_ovr",   32'(overrun),   32'd0);

    // Flush and pop requested together: flush wins, nothing is popped.
    set_entry(0, 8'h77);
    ramadrs = 5'd2; outstrobe = 1'b1; rxd_ready = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; outstrobe = 1'b0;
    check("fp_valid", 32'(rxd_valid), 32'd0);
    check("fp_ptr",   32'(rd_ptr),    32'd2);
    check("fp_rxd",   32'(rxd),       32'h0);
    tick();
    check("final_sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
